regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ write-back requesters (ALU, load, mul).
//  Round-robin arbitration with valid/ready handshake; one registered write per cycle drives register_file.
//  Holds a busy scoreboard, one bit per register, for RAW hazard checks by issue logic.
//  Sits between the execution units and register_file.
// PARAMETERS
//  NUM_REQ   3   number of write-back requesters (>=2)
//  ADDR_W    5   register address width
//  DATA_W    32  register data width
//  NUM_REGS  32  registers tracked by scoreboard (= 2**ADDR_W)
// PORTS
//  clk            in   1                single clock, rising edge
//  rst            in   1                synchronous, active-high reset
//  req_valid      in   NUM_REQ          requester i has a write-back pending
//  req_ready      out  NUM_REQ          requester i accepted this cycle (one-hot or zero)
//  req_addr       in   NUM_REQ*ADDR_W   dest address, slice i = [i*ADDR_W +: ADDR_W]
//  req_data       in   NUM_REQ*DATA_W   write data, slice i = [i*DATA_W +: DATA_W]
//  rf_write_en    out  1                to register_file write_en (registered)
//  rf_write_addr  out  ADDR_W           to register_file write_addr (registered)
//  rf_write_data  out  DATA_W           to register_file write_data (registered)
//  rsv_en         in   1                issue logic reserves a destination register
//  rsv_addr       in   ADDR_W           register being reserved
//  chk_addr1      in   ADDR_W           source operand 1 to hazard-check
//  chk_addr2      in   ADDR_W           source operand 2 to hazard-check
//  chk_busy1      out  1                chk_addr1 has a pending write (combinational)
//  chk_busy2      out  1                chk_addr2 has a pending write (combinational)
//  busy_vec       out  NUM_REGS         raw scoreboard bits (registered)
// BEHAVIOUR
//  - Reset: rf_write_en/addr/data=0, busy_vec=0, RR pointer=0 (req 0 highest priority).
//  - Arbitration combinational: search from pointer upward mod NUM_REQ; first valid i gets req_ready[i]=1.
//    req_ready never depends on anything but req_valid and the pointer; no valid -> req_ready=0.
//  - Transfer = req_valid[i] & req_ready[i]. Requester holds addr/data stable until transfer.
//  - On transfer at edge N: pointer <= (i+1) mod NUM_REQ; rf_write_* loaded with requester i's
//    addr/data, rf_write_en=1 for cycle N+1 only; register_file commits at edge N+1. No transfer -> en=0, pointer holds.
//  - Write to R0: accepted normally (ready asserted, pointer advances) but rf_write_en stays 0.
//  - Throughput one write per cycle; fairness: a waiting valid requester is granted within NUM_REQ cycles.
//  - Scoreboard: rsv_en at edge sets busy[rsv_addr]. Edge where rf_write_en=1 clears busy[rf_write_addr].
//    Same edge set and clear on same address -> set wins (busy stays 1). rsv to R0 ignored; busy[0] always 0.
//    Reserve of already-busy register: stays 1 (single outstanding write per register, issue logic enforces).
//  - chk_busyN = busy[chk_addrN]; chk_addrN==0 -> 0. No bypass of same-cycle rsv_en.
//  - Reset mid-operation: in-flight rf_write is dropped (en=0 next cycle), all busy bits cleared.
// TESTING
//  - Reset, all valid=0 -> req_ready=0, rf_write_en=0, busy_vec=0 for 5 cycles.
//  - Req1 alone, addr=5 data=0x12345678 -> ready[1]=1 one cycle; next cycle en=1 addr=5 data=0x12345678; R5 reads back.
//  - All 3 valid continuously, distinct addrs 1/2/3 -> grants 0,1,2,0,... ; 6 cycles give 6 writes in RR order.
//  - Req0 addr=0 data=0xDEADBEEF -> ready[0]=1, rf_write_en stays 0, register_file R0 reads 0.
//  - rsv_en addr=7 -> chk_busy1(addr 7)=1 next cycle; write-back to R7 -> busy clears at commit edge, chk_busy1=0.
//  - Same-edge rsv R9 and commit to R9 -> busy[9]=1; rst asserted with busy[3:1]=1 and pending write -> all cleared, no write.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port with busy scoreboard
module regfile_wb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write_en,
  output logic [ADDR_W-1:0]         rf_write_addr,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic [ADDR_W-1:0]         chk_addr1,
  input  logic [ADDR_W-1:0]         chk_addr2,
  output logic                      chk_busy1,
  output logic                      chk_busy2,
  output logic [NUM_REGS-1:0]       busy_vec
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  // Rotating priority search starting at the pointer; grant depends only on req_valid and ptr_q.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    ptr_d     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        sel_addr   = req_addr[idx*ADDR_W +: ADDR_W];
        sel_data   = req_data[idx*DATA_W +: DATA_W];
        ptr_d      = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  // R0 writes are consumed from the requester but never reach the register file.
  always_comb begin
    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (grant_any) begin
      en_d   = (sel_addr != '0);
      addr_d = sel_addr;
      data_d = sel_data;
    end
  end

  // Clear on commit first so a same-edge reserve of that register wins.
  always_comb begin
    busy_d = busy_q;
    if (en_q) begin
      busy_d[addr_q] = 1'b0;
    end
    if (rsv_en && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    req_ready     = grant;
    rf_write_en   = en_q;
    rf_write_addr = addr_q;
    rf_write_data = data_q;
    busy_vec      = busy_q;
    chk_busy1     = (chk_addr1 != '0) && busy_q[chk_addr1];
    chk_busy2     = (chk_addr2 != '0) && busy_q[chk_addr2];
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  localparam int NR   = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              rf_write_en;
  logic [AW-1:0]     rf_write_addr;
  logic [DW-1:0]     rf_write_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW-1:0]     chk_addr1;
  logic [AW-1:0]     chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic [NREG-1:0]   busy_vec;

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREG)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Register file sink: commits on the edge where rf_write_en is high.
  logic [DW-1:0] rf_mem [NREG];
  initial for (int i = 0; i < NREG; i++) rf_mem[i] = '0;
  always @(posedge clk) if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] dval(input int r, input int i);
    if (r == 0 && i == 1) return 32'h1234_5678;
    return 32'hC000_0000 | DW'(r << 8) | DW'(i);
  endfunction

  typedef struct {
    logic [NR-1:0] valid;
    logic [AW-1:0] a0, a1, a2;
    logic [NR-1:0] exp_ready;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    int            exp_idx;
  } vec_t;

  vec_t tbl [10];

  // Random-phase reference state
  int              m_ptr;
  logic            m_en;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  logic [NREG-1:0] m_busy, n_busy;
  logic            hold_v [NR];
  logic [AW-1:0]   hold_a [NR];
  logic [DW-1:0]   hold_d [NR];
  int              waitc  [NR];
  int              max_wait;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; chk_addr1 = '0; chk_addr2 = '0;

    tbl[0] = '{3'b010, 5'd1, 5'd5, 5'd3, 3'b010, 1'b1, 5'd5, 1};
    tbl[1] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, 2};
    tbl[2] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, 0};
    tbl[3] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, 1};
    tbl[4] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0, 0};
    tbl[5] = '{3'b001, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, 0};
    tbl[6] = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, 2};
    tbl[7] = '{3'b001, 5'd0, 5'd2, 5'd3, 3'b001, 1'b0, 5'd0, 0};
    tbl[8] = '{3'b011, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, 1};
    tbl[9] = '{3'b110, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, 2};

    // Reset with no requests: outputs quiet every cycle
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("reset_ready", req_ready, 0);
      chk("reset_en", rf_write_en, 0);
      chk("reset_busy", busy_vec, 0);
    end
    @(negedge clk); rst = 1'b0;

    // Table vectors, applied back to back from the reset pointer
    for (int r = 0; r < 10; r++) begin
      set_req(0, tbl[r].valid[0], tbl[r].a0, dval(r, 0));
      set_req(1, tbl[r].valid[1], tbl[r].a1, dval(r, 1));
      set_req(2, tbl[r].valid[2], tbl[r].a2, dval(r, 2));
      #1;
      chk($sformatf("tbl%0d_ready", r), req_ready, tbl[r].exp_ready);
      tick();
      chk($sformatf("tbl%0d_en", r), rf_write_en, tbl[r].exp_en);
      if (tbl[r].exp_en) begin
        chk($sformatf("tbl%0d_addr", r), rf_write_addr, tbl[r].exp_addr);
        chk($sformatf("tbl%0d_data", r), rf_write_data, dval(r, tbl[r].exp_idx));
      end
      @(negedge clk);
    end
    req_valid = '0;
    tick();
    chk("rf_r5_readback", rf_mem[5], 32'h1234_5678);
    chk("rf_r0_stays_zero", rf_mem[0], 0);

    // Reserve R7, then a write-back to R7 clears it at the commit edge
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd0;
    #1 chk("rsv7_no_bypass", chk_busy1, 0);
    tick();
    @(negedge clk); rsv_en = 1'b0;
    #1 chk("rsv7_busy", chk_busy1, 1);
    chk("chk2_r0_zero", chk_busy2, 0);
    set_req(2, 1'b1, 5'd7, 32'hAAAA_0007);
    #1 chk("wb7_ready", req_ready, 3'b100);
    tick();
    chk("wb7_en", rf_write_en, 1);
    chk("wb7_addr", rf_write_addr, 7);
    @(negedge clk); req_valid = '0;
    #1 chk("wb7_busy_until_commit", chk_busy1, 1);
    tick();
    chk("wb7_cleared", chk_busy1, 0);
    chk("wb7_en_one_cycle", rf_write_en, 0);

    // Same-edge reserve and commit on R9: set wins
    @(negedge clk); rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    @(negedge clk); rsv_en = 1'b0; set_req(0, 1'b1, 5'd9, 32'h0000_0009);
    tick();
    @(negedge clk); req_valid = '0; rsv_en = 1'b1; rsv_addr = 5'd9;
    #1 chk("r9_en", rf_write_en, 1);
    chk("r9_addr", rf_write_addr, 9);
    tick();
    chk("r9_set_wins", busy_vec[9], 1);
    @(negedge clk); rsv_en = 1'b0;
    tick();
    chk("r9_still_busy", busy_vec[9], 1);

    // Reset mid-operation drops the pending write and clears the scoreboard
    for (int a = 1; a <= 3; a++) begin
      @(negedge clk); rsv_en = 1'b1; rsv_addr = AW'(a);
      tick();
    end
    @(negedge clk); rsv_en = 1'b0;
    #1 chk("pre_rst_busy", busy_vec[3:1], 3'b111);
    set_req(0, 1'b1, 5'd4, 32'h4);
    set_req(1, 1'b1, 5'd5, 32'h5);
    set_req(2, 1'b1, 5'd6, 32'h6);
    rst = 1'b1;
    tick();
    chk("rst_no_write", rf_write_en, 0);
    chk("rst_busy_clear", busy_vec, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_ptr_zero", req_ready, 3'b001);
    tick();
    chk("post_rst_en", rf_write_en, 1);
    chk("post_rst_addr", rf_write_addr, 4);
    @(negedge clk); req_valid = '0;

    // Randomized traffic against the reference model
    rst = 1'b1;
    tick();
    @(negedge clk); rst = 1'b0;
    m_ptr = 0; m_en = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; max_wait = 0;
    for (int i = 0; i < NR; i++) begin
      hold_v[i] = 1'b0; hold_a[i] = '0; hold_d[i] = '0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int g;
      for (int i = 0; i < NR; i++) begin
        if (!hold_v[i] && $urandom_range(0, 99) < 60) begin
          hold_v[i] = 1'b1;
          hold_a[i] = AW'($urandom_range(0, NREG - 1));
          hold_d[i] = $urandom;
        end
        set_req(i, hold_v[i], hold_a[i], hold_d[i]);
      end
      rsv_en    = ($urandom_range(0, 99) < 30);
      rsv_addr  = AW'($urandom_range(0, NREG - 1));
      chk_addr1 = AW'($urandom_range(0, NREG - 1));
      chk_addr2 = AW'($urandom_range(0, NREG - 1));
      #1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && hold_v[idx]) g = idx;
      end
      chk("rnd_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk("rnd_chk1", chk_busy1, (chk_addr1 != 0) && m_busy[chk_addr1]);
      chk("rnd_chk2", chk_busy2, (chk_addr2 != 0) && m_busy[chk_addr2]);
      chk("rnd_busy_vec", busy_vec, m_busy);

      n_busy = m_busy;
      if (m_en) n_busy[m_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) n_busy[rsv_addr] = 1'b1;
      m_busy = n_busy;
      for (int i = 0; i < NR; i++) begin
        if (hold_v[i] && i != g) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
      if (g >= 0) begin
        m_ptr  = (g + 1) % NR;
        m_en   = (hold_a[g] != 0);
        m_addr = hold_a[g];
        m_data = hold_d[g];
        hold_v[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      tick();
      chk("rnd_en", rf_write_en, m_en);
      if (m_en) begin
        chk("rnd_addr", rf_write_addr, m_addr);
        chk("rnd_data", rf_write_data, m_data);
      end
      @(negedge clk);
    end
    chk("fairness_max_wait_lt_nreq", max_wait < NR, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
